// File: rtl/ahb_ram_slave.sv
// AHB-lite style 64-bit word RAM responder: pipelined address/data phases,
// programmable wait states and read-after-write forwarding. Define AHB_RAM_ERR_EN for range errors.
module ahb_ram_slave #(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [63:0] HADDR,
   input  logic        HWRITE,
   input  logic        HTRANS,
   input  logic [63:0] HWDATA,
   output logic [63:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP
);

   localparam int unsigned AW = $clog2(DEPTH);

`ifdef AHB_RAM_ERR_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

   state_t        state, state_nxt, cap_nxt;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] p_idx, cap_idx;
   logic          p_write;
   logic [3:0]    wcnt;
   logic [63:0]   off;
   logic          capture, cap_err, wr_en, fwd, unused_off;

   assign off        = HADDR - BASE_ADDR;
   assign cap_idx    = off[3 +: AW];
   assign unused_off = ^off;

`ifdef AHB_RAM_ERR_EN
   // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
   assign cap_err = (off >= 64'(DEPTH) * 64'd8);
`else
   assign cap_err = 1'b0;
`endif

   always_comb begin
      HREADY = 1'b1;
`ifdef AHB_RAM_ERR_EN
      HRESP  = 1'b0;
`endif
      case (state)
         S_WAIT: HREADY = 1'b0;
`ifdef AHB_RAM_ERR_EN
         S_ERR1: begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
         end
         S_ERR2: HRESP = 1'b1;
`endif
         default: ;
      endcase
   end

`ifndef AHB_RAM_ERR_EN
   assign HRESP = 1'b0;
`endif

   assign capture = HTRANS && HREADY;
   assign wr_en   = (state == S_DATA) && p_write;
   assign fwd     = wr_en && (p_idx == cap_idx);

   always_comb begin
      cap_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
`ifdef AHB_RAM_ERR_EN
      if (cap_err) cap_nxt = S_ERR1;
`endif
      state_nxt = state;
      case (state)
         S_IDLE: if (capture) state_nxt = cap_nxt;
         S_WAIT: if (wcnt == 4'd0) state_nxt = S_DATA;
         S_DATA: state_nxt = capture ? cap_nxt : S_IDLE;
`ifdef AHB_RAM_ERR_EN
         S_ERR1: state_nxt = S_ERR2;
         S_ERR2: state_nxt = capture ? cap_nxt : S_IDLE;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         p_idx   <= '0;
         p_write <= 1'b0;
         wcnt    <= '0;
         HRDATA  <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            p_idx   <= cap_idx;
            p_write <= HWRITE && !cap_err;
            wcnt    <= 4'(WAIT_STATES - 1);
         end else if (state == S_WAIT) begin
            wcnt <= wcnt - 4'd1;
         end
         // Zero-wait reads load at capture so data is present in the very next cycle.
         if (capture && !HWRITE && !cap_err && (WAIT_STATES == 0))
            HRDATA <= fwd ? HWDATA : mem[cap_idx];
         else if ((state == S_WAIT) && (wcnt == 4'd0) && !p_write)
            HRDATA <= mem[p_idx];
`ifdef AHB_RAM_ERR_EN
         else if (state == S_ERR1)
            HRDATA <= '0;
`endif
      end
   end

   // Write enable derives from reset state, so a reset mid-phase drops the pending write.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[p_idx] <= HWDATA;
   end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: a zero-wait and a three-wait instance driven by random
// and directed transfers, checked against an array model of the word RAM.
module tb_ahb_ram_slave;

   localparam int unsigned DEPTH = 1024;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam int unsigned WS1   = 3;

   typedef struct {
      bit          rd;
      bit          err;
      logic [63:0] data;
      int unsigned waits;
   } exp_t;

   logic        CLK;
   logic        rst_n  [2];
   logic [63:0] haddr  [2];
   logic        hwrite [2];
   logic        htrans [2];
   logic [63:0] hwdata [2];
   logic [63:0] hrdata [2];
   logic        hready [2];
   logic        hresp  [2];

   exp_t        sb [2][$];
   logic [63:0] ref_mem [2][DEPTH];
   int unsigned checks = 0;
   int unsigned errors = 0;

   ahb_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
      .CLK(CLK), .RST_N(rst_n[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]), .HTRANS(htrans[0]),
      .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));

   ahb_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) u_dut1 (
      .CLK(CLK), .RST_N(rst_n[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HTRANS(htrans[1]),
      .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic void chk(input string name, input int g, input logic [63:0] act,
                               input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d: got %h, expected %h", name, g, act, expv);
      end
   endfunction

   function automatic int unsigned widx(input logic [63:0] addr);
      logic [63:0] o = addr - BASE;
      return int'((o >> 3) % 64'(DEPTH));
   endfunction

   function automatic int unsigned ws_of(input int g);
      return (g == 0) ? 0 : WS1;
   endfunction

`ifdef AHB_RAM_ERR_EN
   function automatic bit in_range(input logic [63:0] addr);
      return (addr >= BASE) && (addr < BASE + 64'(DEPTH) * 64'd8);
   endfunction
`endif

   // Entered and left 1 time unit after a rising edge.
   task automatic issue(input int g, input bit wr, input logic [63:0] addr, input logic [63:0] data);
      exp_t        e;
      int unsigned n = 0;
      forever begin
         @(negedge CLK);
         if (hready[g]) break;
         htrans[g] = 1'($urandom);
         haddr[g]  = {$urandom, $urandom};
         hwrite[g] = 1'($urandom);
         n++;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL stall_bound dut%0d: HREADY low %0d cycles, required at most %0d", g, n, 40);
            break;
         end
      end
      htrans[g] = 1'b1;
      haddr[g]  = addr;
      hwrite[g] = wr;
      @(posedge CLK);
      e.rd    = !wr;
      e.err   = 1'b0;
      e.data  = '0;
      e.waits = ws_of(g);
`ifdef AHB_RAM_ERR_EN
      if (!in_range(addr)) begin
         e.err   = 1'b1;
         e.waits = 1;
      end
`endif
      if (!e.err) begin
         if (wr) ref_mem[g][widx(addr)] = data;
         else    e.data = ref_mem[g][widx(addr)];
      end
      sb[g].push_back(e);
      #1;
      htrans[g] = 1'b0;
      if (wr) hwdata[g] = data;
   endtask

   task automatic idle(input int g, input int unsigned n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic reset_mid_write(input int g);
      logic [63:0] old = ref_mem[g][5];
      issue(g, 1'b1, BASE + 64'h28, 64'h0BAD_0BAD_0BAD_0BAD);
      #1;
      rst_n[g] = 1'b0;
      #1;
      chk("rst_hready", g, 64'(hready[g]), 64'd1);
      chk("rst_hresp", g, 64'(hresp[g]), 64'd0);
      chk("rst_hrdata", g, hrdata[g], 64'd0);
      sb[g].delete();
      ref_mem[g][5] = old;
      @(posedge CLK);
      @(posedge CLK);
      #2;
      rst_n[g] = 1'b1;
      idle(g, 1);
      issue(g, 1'b0, BASE + 64'h28, '0);
   endtask

   task automatic run(input int g);
      logic [63:0] addr;
      bit          wr;
      rst_n[g]  = 1'b1;
      htrans[g] = 1'b0;
      hwrite[g] = 1'b0;
      haddr[g]  = '0;
      hwdata[g] = '0;
      #1;
      rst_n[g] = 1'b0;
      #2;
      chk("init_hready", g, 64'(hready[g]), 64'd1);
      chk("init_hresp", g, 64'(hresp[g]), 64'd0);
      chk("init_hrdata", g, hrdata[g], 64'd0);
      @(posedge CLK);
      @(posedge CLK);
      #2;
      rst_n[g] = 1'b1;
      idle(g, 1);

      for (int unsigned i = 0; i < 16; i++)
         issue(g, 1'b1, BASE + 64'(i * 8), {$urandom, $urandom} | 64'h1);
`ifdef AHB_RAM_ERR_EN
      issue(g, 1'b1, BASE + 64'((DEPTH - 1) * 8), 64'h1357_9BDF_2468_ACE0);
`endif
      issue(g, 1'b1, BASE + 64'h28, 64'hDEAD_BEEF_0123_4567);
      issue(g, 1'b0, BASE + 64'h28, '0);
      issue(g, 1'b1, BASE + 64'h10, 64'hA5A5);
      issue(g, 1'b0, BASE + 64'h10, '0);
      issue(g, 1'b0, BASE + 64'h08, '0);
`ifdef AHB_RAM_ERR_EN
      issue(g, 1'b1, BASE - 64'd8, 64'hFFFF_0000_FFFF_0000);
      issue(g, 1'b0, BASE + 64'h08, '0);
      issue(g, 1'b0, BASE + 64'((DEPTH - 1) * 8), '0);
      issue(g, 1'b0, BASE + 64'(DEPTH * 8), '0);
      issue(g, 1'b0, BASE + 64'h10, '0);
`else
      issue(g, 1'b1, BASE + 64'h2008, 64'h77);
      issue(g, 1'b0, BASE + 64'h0008, '0);
`endif
      idle(g, 1);

      for (int unsigned i = 0; i < 250; i++) begin
         wr   = 1'($urandom);
         addr = BASE + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
`ifndef AHB_RAM_ERR_EN
         addr = addr + 64'(DEPTH * 8) * 64'($urandom_range(0, 3));
`endif
         issue(g, wr, addr, {$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) idle(g, $urandom_range(1, 2));
      end
      idle(g, 1);

      issue(g, 1'b0, BASE + 64'h28, '0);
      reset_mid_write(g);
      idle(g, WS1 + 4);
      chk("sb_drained", g, 64'(sb[g].size()), 64'd0);
   endtask

   task automatic monitor(input int g);
      int unsigned waits = 0;
      logic [63:0] last  = '0;
      exp_t        e;
      forever begin
         @(negedge CLK);
         if (!rst_n[g]) begin
            waits = 0;
            last  = '0;
            continue;
         end
         if (sb[g].size() == 0) begin
            chk("idle_hready", g, 64'(hready[g]), 64'd1);
            chk("idle_hresp", g, 64'(hresp[g]), 64'd0);
            chk("idle_hrdata_hold", g, hrdata[g], last);
         end else if (!hready[g]) begin
            waits++;
            chk("wait_hrdata_hold", g, hrdata[g], last);
            if (sb[g][0].err) chk("err1_hresp", g, 64'(hresp[g]), 64'd1);
         end else begin
            e = sb[g].pop_front();
            if (e.err)     last = '0;
            else if (e.rd) last = e.data;
            chk("data_waits", g, 64'(waits), 64'(e.waits));
            chk("data_hresp", g, 64'(hresp[g]), 64'(e.err));
            chk(e.rd ? "read_data" : "write_hrdata_hold", g, hrdata[g], last);
            waits = 0;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      fork
         run(0);
         run(1);
      join
      repeat (4) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      checks++;
      errors++;
      $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
